// File: rtl/en_reg_pipe.sv
// rtl/en_reg_pipe.sv - enabled register pipeline with per-stage valid, flush and occupancy count
module en_reg_pipe #(
    parameter int              WIDTH        = 8,
    parameter int              DEPTH        = 3,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter bit              GATE_INVALID = 1'b1,
    localparam int             CW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;

    // Valid bits: reset and flush clear them, an enabled cycle shifts them one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (en) begin
            v[0] <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
            end
        end
    end

    // Data stages: flush leaves data alone; when gating, a stage only loads a valid word
    // so bubbles do not disturb the previously held data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RST_VAL;
            end
        end else if (!flush && en) begin
            if (!GATE_INVALID || d_valid) begin
                data[0] <= d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (!GATE_INVALID || v[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    // Occupancy is the popcount of the valid flops; its width always covers DEPTH.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(v[i]);
        end
    end

    assign q       = data[DEPTH-1];
    assign q_valid = v[DEPTH-1];

endmodule

// File: tb/tb_en_reg_pipe.sv
// tb/tb_en_reg_pipe.sv - directed self-checking bench for en_reg_pipe
module tb_en_reg_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       d_valid;

    logic [7:0] q_g, q_u;
    logic       qv_g, qv_u;
    logic [1:0] cnt_g, cnt_u;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    en_reg_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .GATE_INVALID(1'b1)) dut_g (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_g), .q_valid(qv_g), .count(cnt_g)
    );

    en_reg_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .GATE_INVALID(1'b0)) dut_u (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q_u), .q_valid(qv_u), .count(cnt_u)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; flush = 1'b0; d = 8'hFF; d_valid = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            n_checks++;
            if (q_g !== 8'h00 || qv_g !== 1'b0 || cnt_g !== 2'd0) begin
                n_fail++;
                $display("FAIL reset edge%0d: q=%h qv=%b cnt=%0d, want q=00 qv=0 cnt=0", e, q_g, qv_g, cnt_g);
            end
            n_checks++;
            if (q_u !== 8'h00 || qv_u !== 1'b0 || cnt_u !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_ungated edge%0d: q=%h qv=%b cnt=%0d, want q=00 qv=0 cnt=0", e, q_u, qv_u, cnt_u);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [7:0] din  [6] = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00};
        logic       vin  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] ecnt [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        logic       eqv  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] eq   [6] = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hC3};
        do_reset();
        en = 1'b1;
        for (int e = 0; e < 6; e++) begin
            d = din[e]; d_valid = vin[e];
            tick();
            n_checks++;
            if (cnt_g !== ecnt[e] || qv_g !== eqv[e] || q_g !== eq[e]) begin
                n_fail++;
                $display("FAIL latency edge%0d: q=%h qv=%b cnt=%0d, want q=%h qv=%b cnt=%0d",
                         e + 1, q_g, qv_g, cnt_g, eq[e], eqv[e], ecnt[e]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1;
        d = 8'h11; d_valid = 1'b1; tick();
        d = 8'h22; d_valid = 1'b1; tick();
        en = 1'b0; d = 8'h99; d_valid = 1'b1;
        for (int e = 0; e < 4; e++) begin
            tick();
            n_checks++;
            if (q_g !== 8'h00 || qv_g !== 1'b0 || cnt_g !== 2'd2) begin
                n_fail++;
                $display("FAIL stall cyc%0d: q=%h qv=%b cnt=%0d, want q=00 qv=0 cnt=2", e, q_g, qv_g, cnt_g);
            end
        end
        en = 1'b1; d = 8'h00; d_valid = 1'b0;
        tick();
        n_checks++;
        if (q_g !== 8'h11 || qv_g !== 1'b1 || cnt_g !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_exit11: q=%h qv=%b cnt=%0d, want q=11 qv=1 cnt=2", q_g, qv_g, cnt_g);
        end
        tick();
        n_checks++;
        if (q_g !== 8'h22 || qv_g !== 1'b1 || cnt_g !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_exit22: q=%h qv=%b cnt=%0d, want q=22 qv=1 cnt=1", q_g, qv_g, cnt_g);
        end
    endtask

    task automatic test_flush();
        do_reset();
        en = 1'b1; d_valid = 1'b1;
        d = 8'h31; tick();
        d = 8'h32; tick();
        d = 8'h33; tick();
        n_checks++;
        if (q_g !== 8'h31 || qv_g !== 1'b1 || cnt_g !== 2'd3) begin
            n_fail++;
            $display("FAIL flush_fill: q=%h qv=%b cnt=%0d, want q=31 qv=1 cnt=3", q_g, qv_g, cnt_g);
        end
        flush = 1'b1; d = 8'h77; d_valid = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if (q_g !== 8'h31 || qv_g !== 1'b0 || cnt_g !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_edge: q=%h qv=%b cnt=%0d, want q=31 qv=0 cnt=0", q_g, qv_g, cnt_g);
        end
        d = 8'h00; d_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks++;
            if (q_g !== 8'h31 || qv_g !== 1'b0 || cnt_g !== 2'd0) begin
                n_fail++;
                $display("FAIL flush_after%0d: q=%h qv=%b cnt=%0d, want q=31 qv=0 cnt=0", e, q_g, qv_g, cnt_g);
            end
        end
    endtask

    task automatic test_bubble();
        logic [7:0] din [5] = '{8'h5A, 8'hEE, 8'h6B, 8'h00, 8'h00};
        logic       vin [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] eqg [3] = '{8'h5A, 8'h5A, 8'h6B};
        logic [7:0] equ [3] = '{8'h5A, 8'hEE, 8'h6B};
        logic       eqv [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        en = 1'b1;
        for (int e = 0; e < 5; e++) begin
            d = din[e]; d_valid = vin[e];
            tick();
            if (e >= 2) begin
                n_checks++;
                if (q_g !== eqg[e-2] || qv_g !== eqv[e-2]) begin
                    n_fail++;
                    $display("FAIL bubble_gated edge%0d: q=%h qv=%b, want q=%h qv=%b",
                             e + 1, q_g, qv_g, eqg[e-2], eqv[e-2]);
                end
                n_checks++;
                if (q_u !== equ[e-2] || qv_u !== eqv[e-2]) begin
                    n_fail++;
                    $display("FAIL bubble_ungated edge%0d: q=%h qv=%b, want q=%h qv=%b",
                             e + 1, q_u, qv_u, equ[e-2], eqv[e-2]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        en = 1'b1; d_valid = 1'b1;
        d = 8'h41; tick();
        d = 8'h42; tick();
        n_checks++;
        if (cnt_g !== 2'd2) begin
            n_fail++;
            $display("FAIL midrst_pre: cnt=%0d, want 2", cnt_g);
        end
        rst = 1'b1; flush = 1'b1; en = 1'b1; d = 8'h55; d_valid = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        n_checks++;
        if (q_g !== 8'h00 || qv_g !== 1'b0 || cnt_g !== 2'd0 || cnt_u !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_edge: q=%h qv=%b cnt=%0d cnt_u=%0d, want q=00 qv=0 cnt=0 cnt_u=0",
                     q_g, qv_g, cnt_g, cnt_u);
        end
        d = 8'h00; d_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks++;
            if (q_u !== 8'h00 || qv_u !== 1'b0 || cnt_u !== 2'd0) begin
                n_fail++;
                $display("FAIL midrst_drain%0d: q=%h qv=%b cnt=%0d, want q=00 qv=0 cnt=0", e, q_u, qv_u, cnt_u);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
        #2;
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_bubble();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
